store_packer: RTL and testbench

Store-side data packer and write buffer for the MIPS datapath; the write-direction counterpart of the load-path zero/sign extenders. It takes register data plus size/address from the MEM stage, places the byte/halfword/word into the correct lanes of a 32-bit memory word with byte enables, and queues up to two stores in front of the data memory behind a req/ack handshake. Misaligned stores are rejected and flagged.

---
 rtl/store_packer.sv | 114 +++++++++++
 tb/tb_store_packer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/store_packer.sv
// Store lane packer + 2-entry in-order write buffer; accept-to-mem_req latency 1 cycle.
// Backpressure: st_ready drops when both entries are held; the head is held stable until mem_ack.
module store_packer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        misalign,
  output logic [31:0] misalign_addr,
  output logic [1:0]  count
);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  entry_t      buf_q [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count_q;
  logic        misalign_q;
  logic [31:0] misalign_addr_q;

  entry_t      pack;
  logic        bad_align;
  logic        accept;
  logic        push;
  logic        pop;

  always_comb begin
    pack       = '0;
    pack.addr  = {st_addr[31:2], 2'b00};
    bad_align  = 1'b0;
    case (st_size)
      2'b00: begin
        pack.wdata = 32'(st_data[7:0]) << {st_addr[1:0], 3'b000};
        pack.be    = 4'b0001 << st_addr[1:0];
      end
      2'b01: begin
        bad_align = st_addr[0];
        if (st_addr[1]) begin
          pack.wdata = {st_data[15:0], 16'h0000};
          pack.be    = 4'b1100;
        end else begin
          pack.wdata = {16'h0000, st_data[15:0]};
          pack.be    = 4'b0011;
        end
      end
      2'b10: begin
        bad_align  = (st_addr[1:0] != 2'b00);
        pack.wdata = st_data;
        pack.be    = 4'b1111;
      end
      default: bad_align = 1'b1;
    endcase
  end

  // Ready comes only from registered count, so a same-cycle pop never frees a slot early.
  assign st_ready = (count_q < 2'(DEPTH));
  assign accept   = st_valid & st_ready;
  assign push     = accept & ~bad_align;
  assign mem_req  = (count_q != 2'd0);
  assign pop      = mem_req & mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_ptr] <= pack;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q      <= 1'b0;
      misalign_addr_q <= 32'h0;
    end else begin
      misalign_q <= accept & bad_align;
      if (accept & bad_align) misalign_addr_q <= st_addr;
    end
  end

  assign mem_addr      = buf_q[rd_ptr].addr;
  assign mem_wdata     = buf_q[rd_ptr].wdata;
  assign mem_be        = buf_q[rd_ptr].be;
  assign count         = count_q;
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_store_packer.sv
// Directed bench for store_packer: packing, misalign, backpressure, wrap and async reset.
module tb_store_packer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic [1:0]  count;

  int checks   = 0;
  int failures = 0;

  store_packer dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .misalign(misalign), .misalign_addr(misalign_addr),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    st_valid = 1'b1;
    st_size  = size;
    st_addr  = addr;
    st_data  = data;
  endtask

  // One store with memory stalled, check the head, then retire it.
  task automatic one_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] e_addr,
                           input logic [31:0] e_wdata, input logic [3:0] e_be);
    mem_ack = 1'b0;
    drive(size, addr, data);
    tick();
    st_valid = 1'b0;
    chk({tag, "_req"},   32'(mem_req), 32'd1);
    chk({tag, "_addr"},  mem_addr, e_addr);
    chk({tag, "_wdata"}, mem_wdata, e_wdata);
    chk({tag, "_be"},    32'(mem_be), 32'(e_be));
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk({tag, "_drained"}, 32'(count), 32'd0);
  endtask

  logic [31:0] dv [11];

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_ack = 1'b0;
    repeat (2) tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be", 32'(mem_be), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_mis", 32'(misalign), 32'd0);
    chk("rst_mis_addr", misalign_addr, 32'h0);
    rst_n = 1'b1;
    tick();

    one_store("sb3", 2'b00, 32'h0000_1003, 32'h0000_00A5, 32'h0000_1000, 32'hA500_0000, 4'b1000);
    one_store("sb0", 2'b00, 32'h0000_1000, 32'hFFFF_FF5A, 32'h0000_1000, 32'h0000_005A, 4'b0001);
    one_store("sh2", 2'b01, 32'h0000_2002, 32'h1234_8001, 32'h0000_2000, 32'h8001_0000, 4'b1100);
    one_store("sh0", 2'b01, 32'h0000_2000, 32'h1234_8001, 32'h0000_2000, 32'h0000_8001, 4'b0011);
    one_store("sw",  2'b10, 32'h0000_2004, 32'hDEAD_BEEF, 32'h0000_2004, 32'hDEAD_BEEF, 4'b1111);

    // Misaligned requests back-to-back: pulse every cycle, address tracks each.
    drive(2'b01, 32'h0000_3001, 32'h1111_1111);
    tick();
    chk("mis_sh", 32'(misalign), 32'd1);
    chk("mis_sh_addr", misalign_addr, 32'h0000_3001);
    chk("mis_sh_count", 32'(count), 32'd0);
    drive(2'b10, 32'h0000_3002, 32'h2222_2222);
    tick();
    chk("mis_sw", 32'(misalign), 32'd1);
    chk("mis_sw_addr", misalign_addr, 32'h0000_3002);
    drive(2'b11, 32'h0000_3000, 32'h3333_3333);
    tick();
    st_valid = 1'b0;
    chk("mis_rsv", 32'(misalign), 32'd1);
    chk("mis_rsv_addr", misalign_addr, 32'h0000_3000);
    chk("mis_rsv_count", 32'(count), 32'd0);
    chk("mis_rsv_req", 32'(mem_req), 32'd0);
    tick();
    chk("mis_clear", 32'(misalign), 32'd0);
    chk("mis_addr_hold", misalign_addr, 32'h0000_3000);

    // Full / backpressure: A, B accepted, C held until A retires.
    drive(2'b10, 32'h0000_4000, 32'hAAAA_0001);
    tick();
    drive(2'b10, 32'h0000_4004, 32'hBBBB_0002);
    tick();
    chk("full_count", 32'(count), 32'd2);
    chk("full_ready", 32'(st_ready), 32'd0);
    drive(2'b10, 32'h0000_4008, 32'hCCCC_0003);
    tick();
    chk("hold_count", 32'(count), 32'd2);
    chk("hold_head", mem_wdata, 32'hAAAA_0001);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("popA_count", 32'(count), 32'd1);
    chk("popA_ready", 32'(st_ready), 32'd1);
    chk("head_B", mem_wdata, 32'hBBBB_0002);
    tick();
    st_valid = 1'b0;
    chk("C_in_count", 32'(count), 32'd2);
    mem_ack = 1'b1;
    tick();
    chk("head_C", mem_wdata, 32'hCCCC_0003);
    chk("head_C_addr", mem_addr, 32'h0000_4008);
    tick();
    mem_ack = 1'b0;
    chk("drain_count", 32'(count), 32'd0);

    // Simultaneous push/pop at count 1; pointers wrap repeatedly.
    for (int i = 0; i < 11; i++) dv[i] = 32'h5000_0000 + 32'(i * 32'h0101_0101);
    drive(2'b10, 32'h0000_5000, dv[0]);
    tick();
    for (int i = 1; i < 11; i++) begin
      drive(2'b10, 32'h0000_5000 + 32'(4 * i), dv[i]);
      mem_ack = 1'b1;
      tick();
      chk($sformatf("pp%0d_count", i), 32'(count), 32'd1);
      chk($sformatf("pp%0d_head", i), mem_wdata, dv[i]);
    end
    st_valid = 1'b0;
    tick();
    mem_ack = 1'b0;
    chk("pp_drain", 32'(count), 32'd0);

    // Async reset while full: outputs clear without a clock edge.
    drive(2'b10, 32'h0000_6000, 32'h6666_0001);
    tick();
    drive(2'b10, 32'h0000_6004, 32'h6666_0002);
    tick();
    st_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd2);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_ready", 32'(st_ready), 32'd1);
    chk("arst_wdata", mem_wdata, 32'h0);
    chk("arst_be", 32'(mem_be), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_req", 32'(mem_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
